// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types and helpers for the load/store unit.
package lsu_pkg;

    localparam int LSU_XLEN  = 64;
    localparam int LSU_AW    = 64;
    localparam int LSU_WDT_W = 4;

    // One-hot access widths as presented on wdt_op
    typedef enum logic [LSU_WDT_W-1:0] {
        WDT8  = 4'b0001,
        WDT16 = 4'b0010,
        WDT32 = 4'b0100,
        WDT64 = 4'b1000
    } wdt_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LCAP,
        ST_STORE,
        ST_RESP
    } lsu_state_e;

    // Captured request; "signed" is a keyword, hence is_signed
    typedef struct packed {
        logic                 is_store;
        logic                 is_signed;
        logic [LSU_WDT_W-1:0] wdt;
        logic [LSU_AW-1:0]    addr;
        logic [LSU_XLEN-1:0]  wdata;
    } lsu_req_t;

    // Anything that is not a legal one-hot width is handled as a 64b access
    function automatic logic [LSU_WDT_W-1:0] norm_wdt(input logic [LSU_WDT_W-1:0] wdt);
        case (wdt)
            WDT8, WDT16, WDT32: return wdt;
            default:            return WDT64;
        endcase
    endfunction

    // Natural alignment check on the low address bits
    function automatic logic misaligned(input logic [LSU_WDT_W-1:0] wdt,
                                        input logic [2:0]           addr_lo);
        case (norm_wdt(wdt))
            WDT8:    return 1'b0;
            WDT16:   return addr_lo[0];
            WDT32:   return |addr_lo[1:0];
            default: return |addr_lo[2:0];
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_ext.sv
// Sign/zero extension of zero-extended RAM read data by access width.
module lsu_ext
    import lsu_pkg::*;
#(
    parameter int XLEN = LSU_XLEN
) (
    input  logic [XLEN-1:0]      rdata,
    input  logic [LSU_WDT_W-1:0] wdt,
    input  logic                 is_signed,
    output logic [XLEN-1:0]      ext_data
);

    // Replicate the top bit of the selected width when signed, else clear upper bits
    always_comb begin
        ext_data = rdata;
        case (wdt)
            WDT8:    ext_data = {{(XLEN-8){is_signed & rdata[7]}}, rdata[7:0]};
            WDT16:   ext_data = {{(XLEN-16){is_signed & rdata[15]}}, rdata[15:0]};
            WDT32:   ext_data = {{(XLEN-32){is_signed & rdata[31]}}, rdata[31:0]};
            default: ext_data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: one op in flight, drives a single-port data RAM and
// returns extended load data / misalign status to write-back.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int XLEN  = LSU_XLEN,
    parameter int AW    = LSU_AW,
    parameter int WDT_W = LSU_WDT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_is_store,
    input  logic             in_signed,
    input  logic [WDT_W-1:0] in_wdt,
    input  logic [AW-1:0]    in_addr,
    input  logic [XLEN-1:0]  in_wdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_rdata,
    output logic             out_misalign,
    output logic [XLEN-1:0]  mem_raddr,
    output logic [AW-1:0]    mem_waddr,
    output logic [XLEN-1:0]  mem_wdata,
    output logic             mem_ren,
    output logic             mem_wen,
    output logic [WDT_W-1:0] wdt_op,
    input  logic [XLEN-1:0]  mem_rdata
);

    lsu_state_e      state_q, state_d;
    lsu_req_t        req_q, req_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] ext_data;

    lsu_ext #(.XLEN(XLEN)) u_ext (
        .rdata     (mem_rdata),
        .wdt       (req_q.wdt),
        .is_signed (req_q.is_signed),
        .ext_data  (ext_data)
    );

    // State, request and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            req_q      <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
        end
    end

    // Next-state logic; result registers only change on accept, capture and release
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        rdata_d    = rdata_q;
        misalign_d = misalign_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    req_d.is_store  = in_is_store;
                    req_d.is_signed = in_signed;
                    req_d.wdt       = norm_wdt(in_wdt);
                    req_d.addr      = in_addr;
                    req_d.wdata     = in_wdata;
                    rdata_d         = '0;
                    if (misaligned(in_wdt, in_addr[2:0])) begin
                        misalign_d = 1'b1;
                        state_d    = ST_RESP;
                    end else begin
                        misalign_d = 1'b0;
                        state_d    = in_is_store ? ST_STORE : ST_LOAD;
                    end
                end
            end
            ST_LOAD:  state_d = ST_LCAP;
            ST_LCAP: begin
                rdata_d = ext_data;
                state_d = ST_RESP;
            end
            ST_STORE: begin
                rdata_d = '0;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (out_ready) begin
                    misalign_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Handshake and RAM strobes decode straight from the state; addresses come from the request
    always_comb begin
        in_ready     = (state_q == ST_IDLE);
        out_valid    = (state_q == ST_RESP);
        mem_ren      = (state_q == ST_LOAD);
        mem_wen      = (state_q == ST_STORE);
        out_rdata    = rdata_q;
        out_misalign = misalign_q;
        mem_raddr    = req_q.addr;
        mem_waddr    = req_q.addr;
        mem_wdata    = req_q.wdata;
        wdt_op       = req_q.wdt;
    end

endmodule
